lc3_mem_ctrl: RTL and testbench

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

---
 rtl/lc3_mem_ctrl_if.sv | 13 +
 rtl/lc3_mem_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_ctrl_if.sv
// Datapath-side memory bus of the LC-3 memory controller: MAR/MDR request
// and the R (ready) completion pulse with read data.
interface lc3_mem_ctrl_if;
    logic        mio_en;
    logic        r_w;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;

    modport master (output mio_en, r_w, addr, wdata, input rdata, ready);
    modport slave  (input mio_en, r_w, addr, wdata, output rdata, ready);
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: routes datapath accesses to a wait-stated SRAM or to
// the memory-mapped keyboard, display and machine-control registers.
module lc3_mem_ctrl #(
    parameter int WAIT_STATES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    lc3_mem_ctrl_if.slave bus,
    output logic          mem_en,
    output logic          mem_we,
    output logic [15:0]   mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          kbd_valid,
    input  logic [7:0]    kbd_data,
    output logic          disp_valid,
    output logic [7:0]    disp_data,
    input  logic          disp_ack,
    output logic          kbd_irq,
    output logic          clk_en
);
    typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [2:0] {TG_SRAM, TG_KBSR, TG_KBDR, TG_DSR, TG_DDR, TG_MCR, TG_NONE} target_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    function automatic target_t decode(input logic [15:0] a);
        target_t t;
        if (a[15:9] == 7'h7F) begin
            case (a)
                16'hFE00: t = TG_KBSR;
                16'hFE02: t = TG_KBDR;
                16'hFE04: t = TG_DSR;
                16'hFE06: t = TG_DDR;
                16'hFFFE: t = TG_MCR;
                default:  t = TG_NONE;
            endcase
        end else begin
            t = TG_SRAM;
        end
        return t;
    endfunction

    state_t      state_r;
    target_t     tgt_r;
    target_t     tgt_s;
    logic        we_r;
    logic [15:0] addr_r;
    logic [15:0] wdata_r;
    logic [3:0]  cnt_r;
    logic        cap_pend_r;
    logic [15:0] cap_r;
    logic [15:0] rdata_r;
    logic        byp_r;
    logic        ready_r;
    logic        mem_en_r;
    logic        mem_we_r;

    logic        kbsr_full_r, kbsr_full_s;
    logic        kbd_ie_r, kbd_ie_s;
    logic [7:0]  kbdr_r, kbdr_s;
    logic        disp_valid_r, disp_valid_s;
    logic [7:0]  disp_data_r, disp_data_s;
    logic [15:0] mcr_r, mcr_s;
    logic        kbd_irq_r, kbd_irq_s;
    logic [15:0] dev_rdata_s;
    logic        kbd_clr_s;
    logic        dev_wr_s;

    assign tgt_s     = decode(bus.addr);
    assign kbd_clr_s = (state_r == ST_RESP) && (tgt_r == TG_KBDR) && !we_r;
    assign dev_wr_s  = (state_r == ST_RESP) && we_r;

    // Device register read mux, evaluated on the request address as it is accepted.
    always_comb begin
        case (tgt_s)
            TG_KBSR: dev_rdata_s = {kbsr_full_r, kbd_ie_r, 14'h0000};
            TG_KBDR: dev_rdata_s = {8'h00, kbdr_r};
            TG_DSR:  dev_rdata_s = {~disp_valid_r, 15'h0000};
            TG_MCR:  dev_rdata_s = mcr_r;
            default: dev_rdata_s = 16'h0000;
        endcase
    end

    // Next values of the device registers; device side effects land at the end of RESP.
    always_comb begin
        kbd_ie_s    = kbd_ie_r;
        kbdr_s      = kbdr_r;
        disp_data_s = disp_data_r;
        mcr_s       = mcr_r;
        // A new character beats the KBDR-read clear when both happen together.
        if (kbd_valid && (!kbsr_full_r || kbd_clr_s)) begin
            kbsr_full_s = 1'b1;
            kbdr_s      = kbd_data;
        end else if (kbd_clr_s) begin
            kbsr_full_s = 1'b0;
        end else begin
            kbsr_full_s = kbsr_full_r;
        end
        if (disp_ack && disp_valid_r) begin
            disp_valid_s = 1'b0;
        end else begin
            disp_valid_s = disp_valid_r;
        end
        if (dev_wr_s) begin
            case (tgt_r)
                TG_KBSR: kbd_ie_s = wdata_r[14];
                TG_DDR: begin
                    if (!disp_valid_r) begin
                        disp_valid_s = 1'b1;
                        disp_data_s  = wdata_r[7:0];
                    end else begin
                        disp_data_s  = disp_data_r;
                    end
                end
                TG_MCR:  mcr_s = wdata_r;
                default: mcr_s = mcr_r;
            endcase
        end else begin
            mcr_s = mcr_r;
        end
        kbd_irq_s = kbsr_full_s & kbd_ie_s;
    end

    // Access FSM with registered bus/SRAM outputs plus the device register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            tgt_r        <= TG_NONE;
            we_r         <= 1'b0;
            addr_r       <= 16'h0000;
            wdata_r      <= 16'h0000;
            cnt_r        <= 4'd0;
            cap_pend_r   <= 1'b0;
            cap_r        <= 16'h0000;
            rdata_r      <= 16'h0000;
            byp_r        <= 1'b0;
            ready_r      <= 1'b0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            kbsr_full_r  <= 1'b0;
            kbd_ie_r     <= 1'b0;
            kbdr_r       <= 8'h00;
            disp_valid_r <= 1'b0;
            disp_data_r  <= 8'h00;
            mcr_r        <= 16'h8000;
            kbd_irq_r    <= 1'b0;
        end else begin
            kbsr_full_r  <= kbsr_full_s;
            kbd_ie_r     <= kbd_ie_s;
            kbdr_r       <= kbdr_s;
            disp_valid_r <= disp_valid_s;
            disp_data_r  <= disp_data_s;
            mcr_r        <= mcr_s;
            kbd_irq_r    <= kbd_irq_s;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            ready_r      <= 1'b0;
            byp_r        <= 1'b0;
            cap_pend_r   <= 1'b0;
            if (cap_pend_r) begin
                cap_r <= mem_rdata;
            end else begin
                cap_r <= cap_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.mio_en) begin
                        addr_r  <= bus.addr;
                        we_r    <= bus.r_w;
                        wdata_r <= bus.wdata;
                        tgt_r   <= tgt_s;
                        if (tgt_s == TG_SRAM) begin
                            state_r  <= ST_MEM;
                            mem_en_r <= 1'b1;
                            mem_we_r <= bus.r_w;
                        end else begin
                            state_r <= ST_RESP;
                            ready_r <= 1'b1;
                            rdata_r <= bus.r_w ? 16'h0000 : dev_rdata_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MEM: begin
                    cap_pend_r <= !we_r;
                    if (WAIT_STATES > 0) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= WAIT_LOAD;
                    end else begin
                        // Zero wait states: SRAM data only arrives during RESP, so pass it through.
                        state_r <= ST_RESP;
                        ready_r <= 1'b1;
                        byp_r   <= !we_r;
                        rdata_r <= 16'h0000;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                        ready_r <= 1'b1;
                        rdata_r <= we_r ? 16'h0000 : (cap_pend_r ? mem_rdata : cap_r);
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = ready_r;
    assign bus.rdata  = byp_r ? mem_rdata : rdata_r;
    assign mem_en     = mem_en_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign disp_valid = disp_valid_r;
    assign disp_data  = disp_data_r;
    assign kbd_irq    = kbd_irq_r;
    assign clk_en     = mcr_r[15];
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Randomised self-checking bench for lc3_mem_ctrl: a WAIT_STATES=2 instance
// with all devices, and a WAIT_STATES=0 instance for SRAM latency.
module tb_lc3_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lc3_mem_ctrl_if bus2();
    lc3_mem_ctrl_if bus0();

    logic        mem_en2, mem_we2, mem_en0, mem_we0;
    logic [15:0] mem_addr2, mem_wdata2, mem_rdata2, mem_addr0, mem_wdata0, mem_rdata0;
    logic        kbd_valid = 1'b0;
    logic [7:0]  kbd_data = 8'h00;
    logic        disp_ack = 1'b0;
    logic        disp_valid, kbd_irq, clk_en, disp_valid0, kbd_irq0, clk_en0;
    logic [7:0]  disp_data, disp_data0;

    lc3_mem_ctrl #(.WAIT_STATES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ack(disp_ack),
        .kbd_irq(kbd_irq), .clk_en(clk_en));

    lc3_mem_ctrl #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0), .kbd_valid(1'b0), .kbd_data(8'h00),
        .disp_valid(disp_valid0), .disp_data(disp_data0), .disp_ack(1'b0),
        .kbd_irq(kbd_irq0), .clk_en(clk_en0));

    // SRAM behavioural models: data appears the cycle after mem_en.
    logic [15:0] sram2 [0:65535];
    logic [15:0] sram0 [0:65535];
    always @(posedge clk) begin
        if (mem_en2) begin
            if (mem_we2) sram2[mem_addr2] <= mem_wdata2;
            else         mem_rdata2 <= sram2[mem_addr2];
        end
        if (mem_en0) begin
            if (mem_we0) sram0[mem_addr0] <= mem_wdata0;
            else         mem_rdata0 <= sram0[mem_addr0];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic        m_full, m_ie, m_busy;
    logic [7:0]  m_kbyte, m_dbyte;
    logic [15:0] m_mcr;
    logic [15:0] ref_mem [logic [16:0]];

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_ie = 1'b0; m_kbyte = 8'h00;
        m_busy = 1'b0; m_dbyte = 8'h00; m_mcr = 16'h8000;
    endtask

    function automatic logic [15:0] model_access(input int sel, input logic wr,
                                                 input logic [15:0] a, input logic [15:0] d);
        logic [15:0] rd;
        logic [16:0] key;
        rd = 16'h0000;
        key = {sel[0], a};
        if (sel == 1 && a >= 16'hFE00) begin
            case (a)
                16'hFE00: begin rd = {m_full, m_ie, 14'h0}; if (wr) m_ie = d[14]; end
                16'hFE02: begin rd = {8'h00, m_kbyte}; if (!wr) m_full = 1'b0; end
                16'hFE04: rd = {~m_busy, 15'h0};
                16'hFE06: if (wr && !m_busy) begin m_busy = 1'b1; m_dbyte = d[7:0]; end
                16'hFFFE: begin rd = m_mcr; if (wr) m_mcr = d; end
                default:  rd = 16'h0000;
            endcase
            if (wr) rd = 16'h0000;
        end else if (wr) begin
            ref_mem[key] = d;
        end else begin
            rd = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
        end
        return rd;
    endfunction

    task automatic drive(input int sel, input logic en, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
        if (sel == 0) begin
            bus0.mio_en = en; bus0.r_w = wr; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus2.mio_en = en; bus2.r_w = wr; bus2.addr = a; bus2.wdata = d;
        end
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "/kbd_irq"}, 16'(kbd_irq), 16'(m_full & m_ie));
        check_val({tag, "/clk_en"}, 16'(clk_en), 16'(m_mcr[15]));
        check_val({tag, "/disp_valid"}, 16'(disp_valid), 16'(m_busy));
        check_val({tag, "/disp_data"}, 16'(disp_data), 16'(m_dbyte));
    endtask

    task automatic access(input int sel, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input string tag);
        logic [15:0] exp_rd, got_rd;
        int lat, n_en, n_we, exp_lat;
        logic got, is_sram;
        is_sram = (sel == 0) || (a < 16'hFE00);
        exp_rd  = model_access(sel, wr, a, d);
        exp_lat = !is_sram ? 1 : ((sel == 0) ? 2 : 4);
        @(negedge clk);
        drive(sel, 1'b1, wr, a, d);
        lat = 0; n_en = 0; n_we = 0; got = 1'b0; got_rd = 16'h0000;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (sel == 0) begin
                n_en += int'(mem_en0); n_we += int'(mem_we0);
                if (bus0.ready) begin got = 1'b1; got_rd = bus0.rdata; end
            end else begin
                n_en += int'(mem_en2); n_we += int'(mem_we2);
                if (bus2.ready) begin got = 1'b1; got_rd = bus2.rdata; end
            end
        end
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, a, 16'h0000);
        @(posedge clk); #1;
        check_val({tag, "/ready"}, 16'(got), 16'd1);
        check_val({tag, "/rdata"}, got_rd, exp_rd);
        check_val({tag, "/latency"}, 16'(lat), 16'(exp_lat));
        check_val({tag, "/mem_en_cycles"}, 16'(n_en), is_sram ? 16'd1 : 16'd0);
        check_val({tag, "/mem_we_cycles"}, 16'(n_we), (is_sram && wr) ? 16'd1 : 16'd0);
        check_val({tag, "/single_pulse"}, 16'(sel == 0 ? bus0.ready : bus2.ready), 16'd0);
        if (sel == 1) check_status(tag);
    endtask

    task automatic kbd_strobe(input logic [7:0] b);
        @(negedge clk);
        kbd_valid = 1'b1; kbd_data = b;
        @(negedge clk);
        kbd_valid = 1'b0;
        if (!m_full) begin m_full = 1'b1; m_kbyte = b; end
    endtask

    task automatic disp_ack_pulse();
        @(negedge clk);
        disp_ack = 1'b1;
        @(negedge clk);
        disp_ack = 1'b0;
        if (m_busy) m_busy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] dev_addrs [6];
        logic [15:0] a, d;
        logic wr;
        int k;
        dev_addrs = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFFFE, 16'hFE08};
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        model_reset();
        #2 rst_n = 1'b0;
        #20;
        check_val("rst/ready", 16'(bus2.ready), 16'd0);
        check_val("rst/rdata", bus2.rdata, 16'h0000);
        check_val("rst/mem_en", 16'(mem_en2), 16'd0);
        check_val("rst/mem_we", 16'(mem_we2), 16'd0);
        check_status("rst");
        check_val("rst0/clk_en", 16'(clk_en0), 16'd1);
        check_val("rst0/irq_disp", {kbd_irq0, disp_valid0, 6'd0, disp_data0}, 16'h0000);
        @(negedge clk) rst_n = 1'b1;

        // SRAM write then read with two wait states, keyboard, display, irq, MCR
        access(1, 1'b1, 16'h3000, 16'h1234, "sram_wr");
        access(1, 1'b0, 16'h3000, 16'h0000, "sram_rd");
        access(1, 1'b0, 16'hFE00, 16'h0000, "kbsr_empty");
        kbd_strobe(8'h41);
        access(1, 1'b0, 16'hFE00, 16'h0000, "kbsr_full");
        kbd_strobe(8'h42);
        access(1, 1'b0, 16'hFE02, 16'h0000, "kbdr_rd");
        access(1, 1'b0, 16'hFE00, 16'h0000, "kbsr_cleared");
        access(1, 1'b1, 16'hFE06, 16'h0058, "ddr_wr");
        access(1, 1'b0, 16'hFE04, 16'h0000, "dsr_busy");
        access(1, 1'b1, 16'hFE06, 16'h0059, "ddr_wr_ignored");
        disp_ack_pulse();
        access(1, 1'b0, 16'hFE04, 16'h0000, "dsr_idle");
        access(1, 1'b1, 16'hFE00, 16'h4000, "kbsr_ie");
        kbd_strobe(8'h33);
        check_status("irq");
        access(1, 1'b1, 16'hFFFE, 16'h0000, "mcr_stop");
        access(1, 1'b0, 16'hFFFE, 16'h0000, "mcr_rd");
        access(1, 1'b0, 16'hFE08, 16'h0000, "unmapped_rd");

        // New character in the same cycle as the KBDR-read RESP
        kbd_strobe(8'h55);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 16'hFE02, 16'h0000);
        @(posedge clk); #1;
        check_val("coin/ready", 16'(bus2.ready), 16'd1);
        check_val("coin/rdata", bus2.rdata, {8'h00, m_kbyte});
        kbd_valid = 1'b1; kbd_data = 8'h66;
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 16'hFE02, 16'h0000);
        @(posedge clk); #1;
        kbd_valid = 1'b0;
        m_full = 1'b1; m_kbyte = 8'h66;
        access(1, 1'b0, 16'hFE00, 16'h0000, "coin_kbsr");
        access(1, 1'b0, 16'hFE02, 16'h0000, "coin_kbdr");

        // Zero wait states
        access(0, 1'b1, 16'h0100, 16'hA5C3, "ws0_wr");
        access(0, 1'b0, 16'h0100, 16'h0000, "ws0_rd");

        // Reset during the MEM cycle of a write: SRAM must not be written
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 16'h3000, 16'hBEEF);
        @(posedge clk); #1;
        check_val("abort/mem_en_pre", 16'(mem_en2), 16'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort/mem_en", 16'(mem_en2), 16'd0);
        check_val("abort/mem_we", 16'(mem_we2), 16'd0);
        drive(1, 1'b0, 1'b0, 16'h3000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("abort/no_ready", 16'(bus2.ready), 16'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        check_status("after_rst");

        // Reset while waiting on a read
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 16'h3000, 16'h0000);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1, 1'b0, 1'b0, 16'h3000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("wait_rst/no_ready", 16'(bus2.ready), 16'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        access(1, 1'b0, 16'h3000, 16'h0000, "after_rst_rd");

        // Randomised mix of SRAM, device and peripheral events
        for (int i = 0; i < 200; i++) begin
            k = int'($urandom_range(0, 9));
            d = 16'($urandom);
            wr = 1'($urandom_range(0, 1));
            if (k <= 3) begin
                a = 16'h3000 + 16'($urandom_range(0, 7));
                if (!ref_mem.exists({1'b1, a})) wr = 1'b1;
                access(1, wr, a, d, "rnd_sram");
            end else if (k == 4) begin
                kbd_strobe(8'($urandom));
            end else if (k == 5) begin
                disp_ack_pulse();
            end else if (k <= 8) begin
                k = int'($urandom_range(0, 5));
                if (k == 1) wr = 1'b0;
                if (k == 3) wr = 1'b1;
                access(1, wr, dev_addrs[k], d, "rnd_dev");
            end else begin
                a = 16'h0100 + 16'($urandom_range(0, 3));
                if (!ref_mem.exists({1'b0, a})) wr = 1'b1;
                access(0, wr, a, d, "rnd_ws0");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
